mux_seq_n: RTL and testbench

Parametrised, registered N:1 channel selector with a buffer, used between layer outputs and the next serial MAC stage of the autoencoder.
- Captures one vector of N_CH words in a single handshake.
- Delivers the words either as an ordered stream (mode 0) or by addressed reads (mode 1).
- Output side uses a valid/ready handshake.
- Out-of-range selects are fully defined: zero data plus an error flag.

---
 rtl/ae_pkg.sv | 7 +
 rtl/mux_n_1.sv | 22 ++
 rtl/mux_seq_n.sv | 99 +++++++++
 tb/tb_mux_seq_n.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ae_pkg.sv
// ae_pkg: state encoding and datapath width shared across the autoencoder datapath.
package ae_pkg;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_ADDR   = 2'd2;
    localparam int DATA_W_DEF = 16;
endpackage

// File: rtl/mux_n_1.sv
// mux_n_1: combinational N:1 word selector over a flat bank; out-of-range index yields zero and o_hit=0.
module mux_n_1 import ae_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int N_CH   = 16,
    parameter int SEL_W  = $clog2(N_CH)
) (
    input  logic [N_CH*DATA_W-1:0] i_bank,
    input  logic [SEL_W-1:0]       i_sel,
    output logic [DATA_W-1:0]      o_data,
    output logic                   o_hit
);
    always_comb begin
        o_data = '0;
        o_hit  = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (i_sel == SEL_W'(k)) begin
                o_data = i_bank[k*DATA_W +: DATA_W];
                o_hit  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mux_seq_n.sv
// mux_seq_n: registered N:1 channel selector with a vector buffer.
// Streams the captured vector in order (mode 0) or serves addressed reads (mode 1).
module mux_seq_n import ae_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int N_CH   = 16,
    parameter int SEL_W  = $clog2(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH*DATA_W-1:0] i_in_flat,
    input  logic                   i_load_valid,
    output logic                   o_load_ready,
    input  logic                   i_load_mode,
    input  logic [SEL_W-1:0]       i_sel,
    input  logic                   i_sel_valid,
    output logic                   o_sel_ready,
    input  logic                   i_release,
    output logic [DATA_W-1:0]      o_out_data,
    output logic [SEL_W-1:0]       o_out_idx,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic                   o_out_last,
    output logic                   o_sel_err,
    output logic                   o_busy
);
    logic [1:0]             r_state;
    logic [N_CH*DATA_W-1:0] r_bank;
    logic [DATA_W-1:0]      r_data;
    logic [SEL_W-1:0]       r_idx;
    logic                   r_valid, r_last, r_err;
    logic [SEL_W-1:0]       w_next_idx, w_mux_sel;
    logic [DATA_W-1:0]      w_mux_data;
    logic                   w_hit, w_out_hs, w_sel_hs, w_load_hs;

    assign o_load_ready = r_state == ST_IDLE;
    assign o_sel_ready  = (r_state == ST_ADDR) & (!r_valid | i_out_ready);
    assign o_busy       = r_state != ST_IDLE;
    assign o_out_data   = r_data;
    assign o_out_idx    = r_idx;
    assign o_out_valid  = r_valid;
    assign o_out_last   = r_last;
    assign o_sel_err    = r_err;
    assign w_out_hs     = r_valid & i_out_ready;
    assign w_sel_hs     = i_sel_valid & o_sel_ready;
    assign w_load_hs    = i_load_valid & o_load_ready;
    assign w_next_idx   = r_idx + SEL_W'(1);
    // One selector serves both modes: the requested index in ADDR, the next stream index otherwise.
    assign w_mux_sel    = (r_state == ST_ADDR) ? i_sel : w_next_idx;

    mux_n_1 #(.DATA_W(DATA_W), .N_CH(N_CH), .SEL_W(SEL_W)) u_mux (
        .i_bank (r_bank),
        .i_sel  (w_mux_sel),
        .o_data (w_mux_data),
        .o_hit  (w_hit)
    );

    always_ff @(posedge clk)
        if (w_load_hs) r_bank <= i_in_flat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_data  <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_load_hs) begin
            r_state <= i_load_mode ? ST_ADDR : ST_STREAM;
            r_valid <= !i_load_mode;
            r_data  <= i_in_flat[DATA_W-1:0];
            r_idx   <= '0;
            r_last  <= 1'b0;
            r_err   <= 1'b0;
        end else if (r_state == ST_STREAM && w_out_hs) begin
            if (r_last) begin
                r_state <= ST_IDLE;
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end else begin
                r_idx  <= w_next_idx;
                r_data <= w_mux_data;
                r_last <= w_next_idx == SEL_W'(N_CH-1);
            end
        end else if (w_sel_hs) begin
            r_valid <= 1'b1;
            r_idx   <= i_sel;
            r_data  <= w_mux_data;
            r_err   <= !w_hit;
        end else if (r_state == ST_ADDR) begin
            if (w_out_hs) begin
                r_valid <= 1'b0;
                r_err   <= 1'b0;
            end
            // Release only takes effect once no word is left waiting for the consumer.
            if (i_release && (!r_valid || i_out_ready)) r_state <= ST_IDLE;
        end
    end
endmodule

// File: tb/tb_mux_seq_n.sv
// tb_mux_seq_n: randomized and directed bench with a transaction-level queue model of mux_seq_n.
module tb_mux_seq_n;
    localparam int DW = 16;
    localparam int N  = 16;
    localparam int SW = 4;
    localparam int N2 = 12;

    logic clk = 1'b0;
    logic rst;
    logic [N*DW-1:0] in_flat;
    logic load_valid, load_mode, sel_valid, rel, out_ready;
    logic [SW-1:0] sel;
    logic load_ready, sel_ready, out_valid, out_last, sel_err, busy;
    logic [DW-1:0] out_data;
    logic [SW-1:0] out_idx;

    logic [N2*DW-1:0] b_in_flat;
    logic b_load_valid, b_load_mode, b_sel_valid, b_rel, b_out_ready;
    logic [SW-1:0] b_sel;
    logic b_load_ready, b_sel_ready, b_out_valid, b_out_last, b_sel_err, b_busy;
    logic [DW-1:0] b_out_data;
    logic [SW-1:0] b_out_idx;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    mux_seq_n #(.DATA_W(DW), .N_CH(N)) dut (
        .clk(clk), .rst(rst), .i_in_flat(in_flat), .i_load_valid(load_valid),
        .o_load_ready(load_ready), .i_load_mode(load_mode), .i_sel(sel),
        .i_sel_valid(sel_valid), .o_sel_ready(sel_ready), .i_release(rel),
        .o_out_data(out_data), .o_out_idx(out_idx), .o_out_valid(out_valid),
        .i_out_ready(out_ready), .o_out_last(out_last), .o_sel_err(sel_err), .o_busy(busy)
    );

    mux_seq_n #(.DATA_W(DW), .N_CH(N2)) dut12 (
        .clk(clk), .rst(rst), .i_in_flat(b_in_flat), .i_load_valid(b_load_valid),
        .o_load_ready(b_load_ready), .i_load_mode(b_load_mode), .i_sel(b_sel),
        .i_sel_valid(b_sel_valid), .o_sel_ready(b_sel_ready), .i_release(b_rel),
        .o_out_data(b_out_data), .o_out_idx(b_out_idx), .o_out_valid(b_out_valid),
        .i_out_ready(b_out_ready), .o_out_last(b_out_last), .o_sel_err(b_sel_err), .o_busy(b_busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: every accepted request becomes a queued expected word; the head must be on the outputs.
    typedef struct {
        logic [DW-1:0] d;
        logic [SW-1:0] i;
        logic          l;
        logic          e;
    } word_t;
    word_t q[$];
    int m_mode = 0;
    logic [DW-1:0] m_bank [N];
    bit m_en = 1'b0;

    always @(negedge clk) begin : mdl
        bit acc_sel, was_empty;
        int mode0;
        if (m_en) begin
            chk("valid", 32'(out_valid), 32'(q.size() != 0));
            chk("busy", 32'(busy), 32'(m_mode != 0));
            chk("load_ready", 32'(load_ready), 32'(m_mode == 0));
            chk("sel_ready", 32'(sel_ready), 32'(m_mode == 2 && (q.size() == 0 || out_ready)));
            if (q.size() != 0) begin
                chk("data", 32'(out_data), 32'(q[0].d));
                chk("idx", 32'(out_idx), 32'(q[0].i));
                chk("last", 32'(out_last), 32'(q[0].l));
                chk("err", 32'(sel_err), 32'(q[0].e));
            end
            if (rst) begin
                q.delete();
                m_mode = 0;
            end else begin
                mode0 = m_mode;
                was_empty = q.size() == 0;
                acc_sel = mode0 == 2 && sel_valid && (was_empty || out_ready);
                if (!was_empty && out_ready) begin
                    if (mode0 == 1 && q[0].l) m_mode = 0;
                    void'(q.pop_front());
                end
                if (mode0 == 2 && rel && !acc_sel && (was_empty || out_ready)) m_mode = 0;
                if (mode0 == 0 && load_valid) begin
                    for (int k = 0; k < N; k++) m_bank[k] = in_flat[k*DW +: DW];
                    m_mode = load_mode ? 2 : 1;
                    if (!load_mode)
                        for (int k = 0; k < N; k++)
                            q.push_back('{d: in_flat[k*DW +: DW], i: SW'(k), l: (k == N-1), e: 1'b0});
                end
                if (acc_sel) q.push_back('{d: m_bank[int'(sel)], i: sel, l: 1'b0, e: 1'b0});
            end
        end
    end

    task automatic idle_inputs();
        load_valid = 0; load_mode = 0; sel_valid = 0; sel = '0; rel = 0; out_ready = 0;
        b_load_valid = 0; b_load_mode = 0; b_sel_valid = 0; b_sel = '0; b_rel = 0; b_out_ready = 0;
    endtask

    task automatic load_a(input logic mode);
        load_valid = 1; load_mode = mode;
        tick();
        load_valid = 0;
    endtask

    initial begin
        int cnt;
        idle_inputs();
        for (int k = 0; k < N; k++) in_flat[k*DW +: DW] = DW'(16'h1000 + k);
        for (int k = 0; k < N2; k++) b_in_flat[k*DW +: DW] = DW'(16'h2000 + k);
        rst = 1;
        repeat (2) tick();
        chk("rst_data", 32'(out_data), 0);
        chk("rst_idx", 32'(out_idx), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_last", 32'(out_last), 0);
        chk("rst_err", 32'(sel_err), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_load_ready", 32'(load_ready), 1);
        m_en = 1;
        rst = 0;
        tick();

        // Stream at full rate
        out_ready = 1;
        load_a(1'b0);
        for (int i = 0; i < N; i++) begin
            chk("t1_data", 32'(out_data), 32'h1000 + 32'(i));
            chk("t1_last", 32'(out_last), 32'(i == N-1));
            tick();
        end
        chk("t1_idle_valid", 32'(out_valid), 0);
        chk("t1_load_ready", 32'(load_ready), 1);

        // Stream with backpressure 1,0,0,1
        out_ready = 0;
        load_a(1'b0);
        cnt = 0;
        for (int c = 0; c < 200 && cnt < N; c++) begin
            out_ready = (c % 4 == 0) || (c % 4 == 3);
            if (out_valid && out_ready) begin
                chk("t2_word", 32'(out_data), 32'h1000 + 32'(cnt));
                cnt++;
            end
            tick();
        end
        out_ready = 0;
        chk("t2_count", 32'(cnt), 32'(N));
        tick();
        chk("t2_idle", 32'(busy), 0);

        // Addressed reads back to back
        load_a(1'b1);
        out_ready = 1; sel_valid = 1; sel = 4'd5;
        tick();
        chk("t3_d5", 32'(out_data), 32'h1005);
        chk("t3_i5", 32'(out_idx), 5);
        sel = 4'd0;
        tick();
        chk("t3_d0", 32'(out_data), 32'h1000);
        chk("t3_i0", 32'(out_idx), 0);
        sel = 4'd15;
        tick();
        chk("t3_d15", 32'(out_data), 32'h100f);
        chk("t3_i15", 32'(out_idx), 15);
        chk("t3_last", 32'(out_last), 0);
        sel_valid = 0; rel = 1;
        tick();
        rel = 0;
        chk("t3_rel_busy", 32'(busy), 0);

        // Out-of-range select on the 12-channel instance
        b_load_valid = 1; b_load_mode = 1;
        tick();
        b_load_valid = 0; b_sel_valid = 1; b_sel = 4'd13; b_out_ready = 1;
        tick();
        chk("t4_oor_data", 32'(b_out_data), 0);
        chk("t4_oor_err", 32'(b_sel_err), 1);
        chk("t4_oor_idx", 32'(b_out_idx), 13);
        chk("t4_oor_valid", 32'(b_out_valid), 1);
        b_sel = 4'd3;
        tick();
        chk("t4_d3", 32'(b_out_data), 32'h2003);
        chk("t4_err0", 32'(b_sel_err), 0);
        b_sel_valid = 0; b_rel = 1;
        tick();
        b_rel = 0;
        chk("t4_idle", 32'(b_busy), 0);

        // Release while a word waits for the consumer
        load_a(1'b1);
        sel_valid = 1; sel = 4'd7; out_ready = 0;
        tick();
        sel_valid = 0; rel = 1;
        tick();
        chk("t6_busy", 32'(busy), 1);
        chk("t6_held", 32'(out_data), 32'h1007);
        rel = 0; out_ready = 1;
        tick();
        chk("t6_drained", 32'(out_valid), 0);
        chk("t6_still_addr", 32'(busy), 1);
        rel = 1;
        tick();
        rel = 0;
        chk("t6_idle", 32'(busy), 0);

        // Reset mid-stream after 7 handshakes
        out_ready = 1;
        load_a(1'b0);
        repeat (7) tick();
        chk("t5_idx7", 32'(out_idx), 7);
        rst = 1;
        tick();
        rst = 0;
        chk("t5_valid", 32'(out_valid), 0);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_load_ready", 32'(load_ready), 1);
        out_ready = 0;
        load_a(1'b0);
        chk("t5_restart_data", 32'(out_data), 32'h1000);
        chk("t5_restart_idx", 32'(out_idx), 0);
        out_ready = 1;
        for (int c = 0; c < 40 && busy; c++) tick();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < N; k++) in_flat[k*DW +: DW] = DW'($urandom);
            load_valid = ($urandom % 4) == 0;
            load_mode = 1'($urandom);
            sel = SW'($urandom);
            sel_valid = 1'($urandom);
            rel = ($urandom % 6) == 0;
            out_ready = ($urandom % 4) != 0;
            rst = ($urandom % 300) == 0;
            tick();
        end
        idle_inputs();
        rst = 0;
        out_ready = 1; rel = 1;
        for (int c = 0; c < 100 && busy; c++) tick();
        chk("drain_idle", 32'(busy), 0);
        rel = 0;
        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
